// File: rtl/instr_encoder_loader_if.sv
// Field-bundle input stream, instruction-memory write port and session status
// of instr_encoder_loader. The loader is the slave; whoever feeds it is the master.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 32
) ();
  // Handshakes: a bundle moves on a rising edge where in_valid && in_ready, and a
  // memory write completes on a rising edge where mem_we && mem_ready. While valid
  // (or mem_we) is high and the transfer has not completed, the payload holds steady.
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [2:0]        op;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [31:0]       imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic              busy;
  logic              done;
  logic              err_op;
  logic              err_imm;
  logic [1:0]        dbg_state;

  modport slave (
    input  start, in_valid, in_last, op, rd, rs1, rs2, imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err_op, err_imm, dbg_state
  );

  modport master (
    output start, in_valid, in_last, op, rd, rs1, rs2, imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err_op, err_imm, dbg_state
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs LW/SW/ADDI/BEQ field bundles into RV32I words and streams them into
// instruction memory. Define ENCODER_RTYPE_EN to also encode op=4 as ADD.
module instr_encoder_loader #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  instr_encoder_loader_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [ADDR_W-1:0] addr;
  logic              busy_q;
  logic              done_q;
  logic              err_op_q;
  logic              err_imm_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [11:0]       i;
  logic [31:0]       enc_word;
  logic              enc_bad_op;
  logic              enc_bad_imm;

  assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = bus.in_valid && bus.in_ready;
  assign pop        = !fifo_empty && bus.mem_ready;

  assign bus.in_ready  = (state == RUN) && !fifo_full;
  assign bus.mem_we    = !fifo_empty;
  assign bus.mem_wdata = fifo_mem[rd_ptr];
  assign bus.mem_addr  = addr;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err_op    = err_op_q;
  assign bus.err_imm   = err_imm_q;
  assign bus.dbg_state = state;

  // BEQ immediates arrive already halved, matching the core's immediate generator.
  assign i = bus.imm[11:0];

  always_comb begin
    enc_word    = 32'h0000_0013;
    enc_bad_op  = 1'b0;
    enc_bad_imm = |bus.imm[31:12];
    case (bus.op)
      3'd0: enc_word = {i, bus.rs1, 3'b010, bus.rd, 7'b0000011};
      3'd1: enc_word = {i[11:5], bus.rs2, bus.rs1, 3'b010, i[4:0], 7'b0100011};
      3'd2: enc_word = {i, bus.rs1, 3'b000, bus.rd, 7'b0010011};
      3'd3: enc_word = {i[11], i[9:4], bus.rs2, bus.rs1, 3'b000, i[3:0], i[10], 7'b1100011};
`ifdef ENCODER_RTYPE_EN
      3'd4: begin
        enc_word    = {7'b0000000, bus.rs2, bus.rs1, 3'b000, bus.rd, 7'b0110011};
        enc_bad_imm = 1'b0;
      end
`endif
      default: enc_bad_op = 1'b1;
    endcase
  end

  // Word storage carries no reset; count/pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= BASE_ADDR;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_op_q  <= 1'b0;
      err_imm_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pop) addr <= addr + ADDR_W'(4);
      if (push) begin
        if (enc_bad_op)  err_op_q  <= 1'b1;
        if (enc_bad_imm) err_imm_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= RUN;
            busy_q    <= 1'b1;
            addr      <= BASE_ADDR;
            err_op_q  <= 1'b0;
            err_imm_q <= 1'b0;
          end
        end
        RUN: begin
          if (push && bus.in_last) state <= DRAIN;
        end
        DRAIN: begin
          // Leave once the final word's write is being accepted (or nothing is left).
          if (fifo_empty || (count == (PTR_W+1)'(1) && pop)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a 32-bit-address instance plus a
// 4-bit-address instance (base 12) that mirrors the same stimulus for wrap checks.
module tb_instr_encoder_loader;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];

  instr_encoder_loader_if #(.ADDR_W(32)) bus ();
  instr_encoder_loader_if #(.ADDR_W(4))  bus2 ();

  instr_encoder_loader #(.ADDR_W(32), .BASE_ADDR(32'd0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  instr_encoder_loader #(.ADDR_W(4), .BASE_ADDR(4'd12), .FIFO_DEPTH(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  assign bus2.start     = bus.start;
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_last   = bus.in_last;
  assign bus2.op        = bus.op;
  assign bus2.rd        = bus.rd;
  assign bus2.rs1       = bus.rs1;
  assign bus2.rs2       = bus.rs2;
  assign bus2.imm       = bus.imm;
  assign bus2.mem_ready = bus.mem_ready;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted write must match the next expected word/address
  always @(negedge clk) begin
    if (rst_n && bus.mem_we && bus.mem_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", bus.mem_wdata, 32'hDEAD_BEEF);
      end else begin
        check("wr_addr", bus.mem_addr, exp_addr_q.pop_front());
        check("wr_data", bus.mem_wdata, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_q.push_back(d);
  endtask

  task automatic do_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_accept();
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic set_fields(input logic [2:0] o, input logic [4:0] d, input logic [4:0] s1,
                            input logic [4:0] s2, input logic [31:0] im, input logic last);
    bus.op = o; bus.rd = d; bus.rs1 = s1; bus.rs2 = s2; bus.imm = im;
    bus.in_last = last; bus.in_valid = 1'b1;
  endtask

  task automatic send(input logic [2:0] o, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im, input logic last);
    set_fields(o, d, s1, s2, im, last);
    wait_accept();
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("busy_at_done", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("busy_after_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    bus.op = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0;
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err_op", 32'(bus.err_op), 32'd0);
    check("rst_err_imm", 32'(bus.err_imm), 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_addr_wrap", 32'(bus2.mem_addr), 32'd12);
    check("rst_state", 32'(bus.dbg_state), 32'd0);

    // single LW, one-word session
    expect_write(32'd0, 32'h0081_2283);
    do_start();
    check("busy_run", 32'(bus.busy), 32'd1);
    send(3'd0, 5'd5, 5'd2, 5'd0, 32'd8, 1'b1);
    check("lw_we_latency", 32'(bus.mem_we), 32'd1);
    check("lw_word", bus.mem_wdata, 32'h0081_2283);
    check("lw_addr", bus.mem_addr, 32'd0);
    wait_done();

    // SW then ADDI; wrap instance goes 12 -> 0
    expect_write(32'd0, 32'h0061_2623);
    expect_write(32'd4, 32'h0050_0093);
    do_start();
    send(3'd1, 5'd0, 5'd2, 5'd6, 32'd12, 1'b0);
    check("sw_word", bus.mem_wdata, 32'h0061_2623);
    check("wrap_first_addr", 32'(bus2.mem_addr), 32'd12);
    send(3'd2, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    check("addi_word", bus.mem_wdata, 32'h0050_0093);
    check("addi_addr", bus.mem_addr, 32'd4);
    check("wrap_second_addr", 32'(bus2.mem_addr), 32'd0);
    wait_done();

    // BEQ and decode round trip of the halved immediate
    expect_write(32'd0, 32'h0020_8363);
    do_start();
    send(3'd3, 5'd0, 5'd1, 5'd2, 32'd3, 1'b1);
    w = bus.mem_wdata;
    check("beq_word", w, 32'h0020_8363);
    check("beq_decode_imm", 32'({w[31], w[7], w[30:25], w[11:8]}), 32'd3);
    check("beq_decode_rs1", 32'(w[19:15]), 32'd1);
    check("beq_decode_rs2", 32'(w[24:20]), 32'd2);
    wait_done();

    // backpressure: FIFO fills after two bundles, head held stable
    bus.mem_ready = 1'b0;
    expect_write(32'd0, 32'h0010_0113);
    expect_write(32'd4, 32'h0020_0193);
    expect_write(32'd8, 32'h0030_0213);
    do_start();
    send(3'd2, 5'd2, 5'd0, 5'd0, 32'd1, 1'b0);
    send(3'd2, 5'd3, 5'd0, 5'd0, 32'd2, 1'b0);
    set_fields(3'd2, 5'd4, 5'd0, 5'd0, 32'd3, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      check("bp_addr_stable", bus.mem_addr, 32'd0);
      check("bp_data_stable", bus.mem_wdata, 32'h0010_0113);
    end
    @(posedge clk); #1 bus.mem_ready = 1'b1;
    @(negedge clk);
    check("bp_no_passthrough", 32'(bus.in_ready), 32'd0);
    wait_accept();
    wait_done();

    // unsupported op with oversize immediate
    expect_write(32'd0, 32'h0000_0013);
    do_start();
    send(3'd7, 5'd1, 5'd0, 5'd0, 32'h0000_1000, 1'b1);
    wait_done();
    check("err_op_sticky", 32'(bus.err_op), 32'd1);
    check("err_imm_sticky", 32'(bus.err_imm), 32'd1);
    do_start();
    check("err_op_cleared", 32'(bus.err_op), 32'd0);
    check("err_imm_cleared", 32'(bus.err_imm), 32'd0);
    expect_write(32'd0, 32'h0050_0093);
    send(3'd2, 5'd1, 5'd0, 5'd0, 32'h0000_1005, 1'b1);
    wait_done();
    check("trunc_err_imm", 32'(bus.err_imm), 32'd1);
    check("trunc_err_op", 32'(bus.err_op), 32'd0);

    // op=4: ADD when the R-type option is built in, otherwise a NOP
    do_start();
`ifdef ENCODER_RTYPE_EN
    expect_write(32'd0, 32'h0020_81B3);
    send(3'd4, 5'd3, 5'd1, 5'd2, 32'hFFFF_FFFF, 1'b1);
    wait_done();
    check("add_err_op", 32'(bus.err_op), 32'd0);
    check("add_err_imm", 32'(bus.err_imm), 32'd0);
`else
    expect_write(32'd0, 32'h0000_0013);
    send(3'd4, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
    wait_done();
    check("add_off_err_op", 32'(bus.err_op), 32'd1);
`endif

    // reset mid-session drops pending words
    bus.mem_ready = 1'b0;
    do_start();
    send(3'd2, 5'd7, 5'd0, 5'd0, 32'd9, 1'b0);
    @(negedge clk);
    check("mid_we_pending", 32'(bus.mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_we", 32'(bus.mem_we), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_we_wrap", 32'(bus2.mem_we), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_no_write", 32'(bus.mem_we), 32'd0);
    end
    check("post_rst_state", 32'(bus.dbg_state), 32'd0);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
